vga_pixel_reader: RTL and testbench
===================================

// Module: vga_pixel_reader
// PURPOSE
//  Scan-out side of the frame buffer: the draw unit writes colour indices into
//  the imagebuffer and this block reads them back in raster order.
//  - Prefetches indices through a small FIFO.
//  - Expands each index to 10-bit RGB.
//  - Presents one pixel per VGA_Read pulse to the VGA controller.
//  - Sits between the colour-map read port and the VGA_RED/GREEN/BLUE outputs of cpu_pru.
// PARAMETERS
//  H_RES       640  pixels per line
//  V_RES       480  lines per frame
//  CW          4    colour-index width (imagebuffer entry width)
//  AW          19   frame-buffer address width (>= clog2(H_RES*V_RES))
//  FIFO_DEPTH  8    prefetch entries; power of two, >= 4
// PORTS
//  clk          in   1   system clock (only clock)
//  rst_n        in   1   asynchronous active-low reset
//  frame_start  in   1   1-cycle pulse at vertical blank: restart at pixel 0
//  VGA_Read     in   1   1-cycle pulse: VGA controller consumes one pixel
//  fb_rd_en     out  1   frame-buffer read request
//  fb_rd_addr   out  AW  read address, y*H_RES+x
//  fb_rd_data   in   CW  read data, valid exactly 1 cycle after accepted fb_rd_en
//  fb_rd_stall  in   1   arbiter busy; fb_rd_en is not accepted while high
//  VGA_RED      out  10  red channel
//  VGA_GREEN    out  10  green channel
//  VGA_BLUE     out  10  blue channel
//  pixel_ready  out  1   FIFO has primed since last frame_start
//  underflow    out  1   sticky: VGA_Read seen with FIFO empty
// BEHAVIOUR
//  Reset values (async, rst_n low):
//   - All outputs 0. FIFO empty. Fetch address 0. State IDLE.
//  Read acceptance and FIFO:
//   - A read is accepted on a cycle with fb_rd_en=1 and fb_rd_stall=0.
//   - fb_rd_en is combinational from state and credit. It may be high while stalled.
//   - fb_rd_addr holds its value until the read is accepted.
//   - Credit = FIFO count + reads in flight (0 or 1). Issue only while credit < FIFO_DEPTH.
//   - FIFO must never overflow.
//   - Returned data is pushed the cycle after acceptance.
//  Fetch address:
//   - Increments by 1 per accepted read.
//   - Wraps from H_RES*V_RES-1 to 0.
//  State machine:
//   - IDLE: no reads issued. frame_start moves to FILL.
//   - FILL: issue reads. When FIFO count reaches FIFO_DEPTH, go to RUN and set pixel_ready=1.
//   - RUN: issue reads whenever credit allows.
//   - frame_start in any state:
//     - flush the FIFO; set fetch address to 0;
//     - drop any in-flight return (next-cycle data is not pushed);
//     - clear underflow and pixel_ready; go to FILL.
//   - frame_start takes priority over a same-cycle VGA_Read; that VGA_Read is ignored.
//  Output, VGA_Read with FIFO non-empty:
//   - Pop the head entry.
//   - VGA_* are registered and update the cycle after VGA_Read (latency 1).
//   - VGA_* hold their value until the next VGA_Read.
//  Output, VGA_Read with FIFO empty:
//   - VGA_* become 0 next cycle; underflow is set.
//   - Fetch address is not adjusted; re-alignment happens only at the next frame_start.
//  Simultaneous push and pop in one cycle:
//   - Both happen; count is unchanged.
//   - A pop on an empty FIFO with a same-cycle push is NOT allowed: this is an underflow; the pushed entry is kept.
//  Palette, index i (CW=4):
//   - lvl = i[3] ? 10'h3FF : 10'h200
//   - RED = i[0] ? lvl : 0; GREEN = i[1] ? lvl : 0; BLUE = i[2] ? lvl : 0
//   - Examples: 0 -> black; 15 -> white 3FF/3FF/3FF; 9 -> 3FF/000/000.
//   - For CW > 4, upper index bits are ignored.
// TESTING
//  1 Reset, then frame_start, fb_rd_data=addr[3:0], no stall.
//    -> addresses 0..7 issued back-to-back; pixel_ready=1 eight cycles after the first return.
//  2 After (1), VGA_Read every 4th cycle for 20 pulses.
//    -> VGA_* sequence follows the palette for indices 0,1,...,15,0,...
//    -> e.g. pulse 10 (idx 9) gives RED=3FF, GREEN=000, BLUE=000; underflow stays 0.
//  3 Hold fb_rd_stall=1 for 30 cycles while VGA_Read pulses every cycle.
//    -> 8 pixels delivered, then VGA_*=0 and underflow=1.
//    -> fb_rd_addr stable during the stall; the FIFO never exceeds 8 entries.
//  4 Force fetch address to 307198 (preload via frame_start, then consume).
//    -> addresses 307198, 307199, 0, 1 issued in order.
//  5 frame_start in the cycle after an accepted read at address 50.
//    -> the returned data is not pushed; next issued address is 0; underflow cleared.
//  6 rst_n low mid-RUN, asynchronous to clk.
//    -> all outputs 0 immediately; no fb_rd_en until the next frame_start.

Source files
------------

// File: rtl/vga_pixel_reader_if.sv
// Frame-buffer read port between the pixel reader (master) and the
// imagebuffer arbiter (slave).
interface vga_pixel_reader_if #(
    parameter int AW = 19,
    parameter int CW = 4
);
    logic          fb_rd_en;
    logic [AW-1:0] fb_rd_addr;
    logic [CW-1:0] fb_rd_data;
    logic          fb_rd_stall;

    modport master (
        output fb_rd_en,
        output fb_rd_addr,
        input  fb_rd_data,
        input  fb_rd_stall
    );

    modport slave (
        input  fb_rd_en,
        input  fb_rd_addr,
        output fb_rd_data,
        output fb_rd_stall
    );
endinterface

// File: rtl/vga_pixel_reader.sv
// Raster-order scan-out of the imagebuffer: prefetches colour indices into a
// small FIFO and expands one per VGA_Read pulse to 10-bit RGB.
module vga_pixel_reader #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int CW         = 4,
    parameter int AW         = 19,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 VGA_Read,
    vga_pixel_reader_if.master   fb,
    output logic [9:0]           VGA_RED,
    output logic [9:0]           VGA_GREEN,
    output logic [9:0]           VGA_BLUE,
    output logic                 pixel_ready,
    output logic                 underflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(H_RES * V_RES - 1);
    localparam logic [PW:0]    DEPTH_C   = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          inflight_reg;
    logic [PW:0]   count_reg, count_next;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] fifo_mem [FIFO_DEPTH];

    logic [PW:0]   credit;
    logic          issue, accept, push, pop, under, rd_req;
    logic [CW-1:0] head_idx;
    logic [9:0]    lvl;
    logic [9:0]    head_chan [3];

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        count_next = count_reg;
        credit     = count_reg + {{PW{1'b0}}, inflight_reg};
        // No request is raised in a restart cycle so nothing from the old frame is accepted.
        issue      = (state_reg != IDLE) && !frame_start && (credit < DEPTH_C);
        accept     = issue && !fb.fb_rd_stall;
        push       = inflight_reg && !frame_start;
        rd_req     = VGA_Read && !frame_start;
        pop        = rd_req && (count_reg != '0);
        under      = rd_req && (count_reg == '0);

        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (accept) begin
            addr_next = (addr_reg == LAST_ADDR) ? '0 : addr_reg + AW'(1);
        end

        if (frame_start) begin
            state_next = FILL;
            addr_next  = '0;
            count_next = '0;
        end else if (state_reg == FILL && count_next == DEPTH_C) begin
            state_next = RUN;
        end
    end

    assign fb.fb_rd_en   = issue;
    assign fb.fb_rd_addr = addr_reg;

    // Palette: bit 3 selects full/half intensity, bits 0..2 enable R/G/B.
    assign head_idx = fifo_mem[rd_ptr_reg];
    assign lvl      = head_idx[3] ? 10'h3FF : 10'h200;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign head_chan[gi] = head_idx[gi] ? lvl : 10'h000;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= fb.fb_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            VGA_RED      <= '0;
            VGA_GREEN    <= '0;
            VGA_BLUE     <= '0;
            pixel_ready  <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            inflight_reg <= accept;
            count_reg    <= count_next;

            if (frame_start) begin
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                pixel_ready <= 1'b0;
                underflow   <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (state_reg == FILL && state_next == RUN) begin
                    pixel_ready <= 1'b1;
                end
                if (under) begin
                    underflow <= 1'b1;
                end
            end

            if (pop) begin
                VGA_RED   <= head_chan[0];
                VGA_GREEN <= head_chan[1];
                VGA_BLUE  <= head_chan[2];
            end else if (under) begin
                VGA_RED   <= '0;
                VGA_GREEN <= '0;
                VGA_BLUE  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_pixel_reader.sv
// Scoreboard bench for vga_pixel_reader on a 16x4 frame so address wrap is
// reachable; the frame buffer returns addr[3:0] as the colour index.
module tb_vga_pixel_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       VGA_Read;
    logic [9:0] VGA_RED, VGA_GREEN, VGA_BLUE;
    logic       pixel_ready, underflow;

    vga_pixel_reader_if #(.AW(19), .CW(4)) bus ();

    vga_pixel_reader #(
        .H_RES(16), .V_RES(4), .CW(4), .AW(19), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .VGA_Read(VGA_Read),
        .fb(bus), .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
        .pixel_ready(pixel_ready), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] rgb;
        logic        uf;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [18:0] acc_log[$];
    int          acc_cyc[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          pix_no = 0;
    logic [29:0] pal_tab [16];

    // Hand-computed palette {RED, GREEN, BLUE} for indices 0..15.
    initial begin
        pal_tab[0]  = {10'h000, 10'h000, 10'h000};
        pal_tab[1]  = {10'h200, 10'h000, 10'h000};
        pal_tab[2]  = {10'h000, 10'h200, 10'h000};
        pal_tab[3]  = {10'h200, 10'h200, 10'h000};
        pal_tab[4]  = {10'h000, 10'h000, 10'h200};
        pal_tab[5]  = {10'h200, 10'h000, 10'h200};
        pal_tab[6]  = {10'h000, 10'h200, 10'h200};
        pal_tab[7]  = {10'h200, 10'h200, 10'h200};
        pal_tab[8]  = {10'h000, 10'h000, 10'h000};
        pal_tab[9]  = {10'h3FF, 10'h000, 10'h000};
        pal_tab[10] = {10'h000, 10'h3FF, 10'h000};
        pal_tab[11] = {10'h3FF, 10'h3FF, 10'h000};
        pal_tab[12] = {10'h000, 10'h000, 10'h3FF};
        pal_tab[13] = {10'h3FF, 10'h000, 10'h3FF};
        pal_tab[14] = {10'h000, 10'h3FF, 10'h3FF};
        pal_tab[15] = {10'h3FF, 10'h3FF, 10'h3FF};
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-buffer model: index = low address bits, one cycle latency.
    always @(posedge clk) bus.fb_rd_data <= bus.fb_rd_addr[3:0];

    always @(posedge clk) begin
        if (rst_n && bus.fb_rd_en && !bus.fb_rd_stall) begin
            acc_log.push_back(bus.fb_rd_addr);
            acc_cyc.push_back(cyc);
        end
    end

    // Monitor: every honoured VGA_Read yields one pixel one cycle later.
    always @(posedge clk) begin
        if (rst_n && VGA_Read && !frame_start) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pixel_unexpected got=%h/%h/%h uf=%b", VGA_RED, VGA_GREEN, VGA_BLUE, underflow);
            end else begin
                mon_e = exp_q.pop_front();
                if ({VGA_RED, VGA_GREEN, VGA_BLUE} !== mon_e.rgb || underflow !== mon_e.uf) begin
                    failures++;
                    $display("FAIL pixel%0d got=%h/%h/%h uf=%b want=%h/%h/%h uf=%b", pix_no,
                             VGA_RED, VGA_GREEN, VGA_BLUE, underflow,
                             mon_e.rgb[29:20], mon_e.rgb[19:10], mon_e.rgb[9:0], mon_e.uf);
                end else begin
                    $display("pixel%0d ok rgb=%h/%h/%h uf=%b", pix_no, VGA_RED, VGA_GREEN, VGA_BLUE, underflow);
                end
            end
            pix_no++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end else begin
            $display("check %s ok value=%0h", name, got);
        end
    endtask

    // Called at a negedge; drives one VGA_Read cycle and queues its expectation.
    task automatic pulse(input int idx, input bit zero, input bit uf);
        exp_t e;
        e.rgb = zero ? 30'h0 : pal_tab[idx % 16];
        e.uf  = uf;
        exp_q.push_back(e);
        VGA_Read = 1'b1;
        @(negedge clk);
        VGA_Read = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!pixel_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, pixel_ready}, 32'h1);
    endtask

    task automatic restart();
        frame_start = 1'b1;
        acc_log.delete();
        acc_cyc.delete();
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        int n_before;
        int en_seen;
        int k;
        bit found;

        rst_n = 1'b1;
        frame_start = 1'b0;
        VGA_Read = 1'b0;
        bus.fb_rd_stall = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_vga", {2'b0, VGA_RED, VGA_GREEN, VGA_BLUE}, 32'h0);
        check("rst_flags", {29'h0, pixel_ready, underflow, bus.fb_rd_en}, 32'h0);
        check("rst_addr", {13'h0, bus.fb_rd_addr}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_reads", acc_log.size(), 32'h0);

        // 1: fill from pixel 0
        restart();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 8) check("fill_ready_early", {31'h0, pixel_ready}, 32'h0);
            if (i == 9) check("fill_ready", {31'h0, pixel_ready}, 32'h1);
        end
        check("fill_count", acc_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++) check($sformatf("fill_addr%0d", i), {13'h0, acc_log[i]}, i);
        if (acc_cyc.size() >= 8) check("fill_b2b", acc_cyc[7] - acc_cyc[0], 32'd7);

        // 2: paced reads, indices 0..15,0..3
        for (int i = 0; i < 20; i++) begin
            pulse(i, 1'b0, 1'b0);
            repeat (3) @(negedge clk);
        end
        check("paced_no_underflow", {31'h0, underflow}, 32'h0);
        repeat (12) @(negedge clk);

        // 3: stall with a read every cycle
        n_before = acc_log.size();
        bus.fb_rd_stall = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5 || i == 29) begin
                check($sformatf("stall_addr_%0d", i), {13'h0, bus.fb_rd_addr}, 32'd28);
                check($sformatf("stall_en_%0d", i), {31'h0, bus.fb_rd_en}, 32'h1);
            end
            pulse(20 + i, i >= 8, i >= 8);
        end
        check("stall_no_accepts", acc_log.size() - n_before, 32'h0);
        bus.fb_rd_stall = 1'b0;
        repeat (20) @(negedge clk);

        // 4: restart with a same-cycle VGA_Read, then run past the wrap
        VGA_Read = 1'b1;
        restart();
        VGA_Read = 1'b0;
        check("restart_uf_clear", {31'h0, underflow}, 32'h0);
        check("restart_ready_clear", {31'h0, pixel_ready}, 32'h0);
        check("restart_read_ignored", {22'h0, VGA_BLUE}, 32'h0);
        wait_ready("wrap_ready");
        for (int i = 0; i < 60; i++) begin
            pulse(i, 1'b0, 1'b0);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("wrap_log_size", {31'h0, acc_log.size() >= 66}, 32'h1);
        if (acc_log.size() >= 66) begin
            check("wrap_a62", {13'h0, acc_log[62]}, 32'd62);
            check("wrap_a63", {13'h0, acc_log[63]}, 32'd63);
            check("wrap_a64", {13'h0, acc_log[64]}, 32'd0);
            check("wrap_a65", {13'h0, acc_log[65]}, 32'd1);
        end

        // 5: underflow, then restart right after the read of address 50
        restart();
        pulse(0, 1'b1, 1'b1);
        wait_ready("drop_ready");
        k = 0;
        found = 1'b0;
        for (int it = 0; it < 400 && !found; it++) begin
            VGA_Read = 1'b0;
            if (bus.fb_rd_en && !bus.fb_rd_stall && bus.fb_rd_addr == 19'd50) begin
                found = 1'b1;
                @(negedge clk);
            end else if (it % 2 == 0) begin
                pulse(k, 1'b0, 1'b1);
                k++;
            end else begin
                @(negedge clk);
            end
        end
        check("drop_found_addr50", {31'h0, found}, 32'h1);
        restart();
        check("drop_uf_clear", {31'h0, underflow}, 32'h0);
        check("drop_ready_clear", {31'h0, pixel_ready}, 32'h0);
        wait_ready("drop_refill");
        if (acc_log.size() > 0) check("drop_next_addr", {13'h0, acc_log[0]}, 32'h0);
        pulse(0, 1'b0, 1'b0);
        @(negedge clk);
        pulse(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // 6: asynchronous reset mid-cycle while running
        #2 rst_n = 1'b0;
        #1;
        check("arst_vga", {2'b0, VGA_RED, VGA_GREEN, VGA_BLUE}, 32'h0);
        check("arst_flags", {29'h0, pixel_ready, underflow, bus.fb_rd_en}, 32'h0);
        check("arst_addr", {13'h0, bus.fb_rd_addr}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.fb_rd_en) en_seen++;
        end
        check("arst_idle", en_seen, 32'h0);
        restart();
        wait_ready("arst_refill");
        pulse(0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
